// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman job controller: FSM state encoding,
// job-parameter field layout and the default engine result width.
`ifndef V_E_F_Bit
  `define V_E_F_Bit 16
`endif

package sw_pkg;

  localparam int RESULT_W = `V_E_F_Bit;

  localparam int JOB_W        = 16;
  localparam int FIELD_W      = 4;
  localparam int MATCH_LSB    = 12;
  localparam int MISMATCH_LSB = 8;
  localparam int ALPHA_LSB    = 4;
  localparam int BETA_LSB     = 0;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_SET_T,
    ST_WAIT_T,
    ST_READY,
    ST_LOAD,
    ST_START,
    ST_GUARD,
    ST_WAIT_V,
    ST_WAIT_DONE,
    ST_OUT,
    ST_ERROR
  } state_e;

  function automatic logic [FIELD_W-1:0] job_field(input logic [JOB_W-1:0] job,
                                                   input int lsb);
    return job[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/sw_job_fifo.sv
// Job FIFO for the controller. A push while full is accepted when a pop
// happens in the same cycle, because the freed slot is the one being written.
module sw_job_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sw_job_controller.sv
// Sequences scoring jobs into a Smith-Waterman engine and returns tagged results.
// Optional running-maximum tracker enabled with `define SW_BEST_SCORE_EN.
module sw_job_controller
  import sw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 50000,
  parameter int RES_W      = RESULT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_job_valid,
  input  logic [15:0]      i_job_param,
  output logic             o_job_ready,
  output logic             o_set_t,
  output logic             o_start_cal,
  output logic [3:0]       o_match,
  output logic [3:0]       o_mismatch,
  output logic [3:0]       o_minusAlpha,
  output logic [3:0]       o_minusBeta,
  input  logic             i_busy,
  input  logic             i_valid,
  input  logic [RES_W-1:0] i_result,
  output logic             o_res_valid,
  output logic [RES_W-1:0] o_res_data,
  output logic [2:0]       o_res_tag,
  input  logic             i_res_ready,
  output logic             o_error,
  output logic [RES_W-1:0] o_best_score,
  output logic [2:0]       o_best_tag
);

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [JOB_W-1:0]   fifo_head;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               capture;
  logic [3:0]         match_q, mismatch_q, alpha_q, beta_q;
  logic [2:0]         tag_cnt_q, cur_tag_q;
  logic [RES_W-1:0]   res_data_q;

  // Ready also covers the full case when READY frees a slot this very cycle.
  assign o_job_ready = !(state_q inside {ST_INIT, ST_ERROR}) && (!fifo_full || fifo_pop);
  assign fifo_push   = i_job_valid && o_job_ready;

  sw_job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (i_job_param),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_INIT:  state_d = ST_SET_T;
      ST_SET_T: state_d = ST_WAIT_T;
      ST_WAIT_T: begin
        // The engine may not raise busy until a cycle after set_t.
        if (cnt_q != '0 && !i_busy) state_d = ST_READY;
        else if (cnt_q == CNT_LAST) state_d = ST_ERROR;
      end
      ST_READY: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_GUARD;
      ST_GUARD: state_d = ST_WAIT_V;
      ST_WAIT_V: begin
        if (i_valid) begin
          capture = 1'b1;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERROR;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_busy) state_d = ST_OUT;
        else if (cnt_q == CNT_LAST) state_d = ST_ERROR;
      end
      ST_OUT:   if (i_res_ready) state_d = ST_READY;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_INIT;
    endcase
    // Counter restarts on every state change, so each wait state sees 0 first.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      match_q    <= '0;
      mismatch_q <= '0;
      alpha_q    <= '0;
      beta_q     <= '0;
      tag_cnt_q  <= '0;
      cur_tag_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fifo_pop) begin
        match_q    <= job_field(fifo_head, MATCH_LSB);
        mismatch_q <= job_field(fifo_head, MISMATCH_LSB);
        alpha_q    <= job_field(fifo_head, ALPHA_LSB);
        beta_q     <= job_field(fifo_head, BETA_LSB);
        cur_tag_q  <= tag_cnt_q;
        tag_cnt_q  <= tag_cnt_q + 1'b1;
      end
      if (capture) res_data_q <= i_result;
    end
  end

`ifdef SW_BEST_SCORE_EN
  logic [RES_W-1:0] best_score_q;
  logic [2:0]       best_tag_q;

  // Strictly greater: a tie keeps the tag of the earlier job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_score_q <= '0;
      best_tag_q   <= '0;
    end else if (capture && (i_result > best_score_q)) begin
      best_score_q <= i_result;
      best_tag_q   <= cur_tag_q;
    end
  end

  assign o_best_score = best_score_q;
  assign o_best_tag   = best_tag_q;
`else
  assign o_best_score = '0;
  assign o_best_tag   = '0;
`endif

  assign o_set_t      = (state_q == ST_SET_T);
  assign o_start_cal  = (state_q == ST_START);
  assign o_res_valid  = (state_q == ST_OUT);
  assign o_error      = (state_q == ST_ERROR);
  assign o_match      = match_q;
  assign o_mismatch   = mismatch_q;
  assign o_minusAlpha = alpha_q;
  assign o_minusBeta  = beta_q;
  assign o_res_data   = res_data_q;
  assign o_res_tag    = cur_tag_q;

endmodule

// File: tb/tb_sw_job_controller.sv
// Directed, table-driven bench for sw_job_controller with a hand-driven engine.
module tb_sw_job_controller;

  typedef struct {
    logic [15:0] param;
    logic [15:0] result;
    logic [3:0]  e_match;
    logic [3:0]  e_mis;
    logic [3:0]  e_alpha;
    logic [3:0]  e_beta;
    logic [15:0] e_data;
    logic [2:0]  e_tag;
  } vec_t;

  logic        clk, rst_n;
  logic        i_job_valid, i_busy, i_valid, i_res_ready;
  logic [15:0] i_job_param, i_result;
  logic        o_job_ready, o_set_t, o_start_cal, o_res_valid, o_error;
  logic [3:0]  o_match, o_mismatch, o_minusAlpha, o_minusBeta;
  logic [15:0] o_res_data, o_best_score;
  logic [2:0]  o_res_tag, o_best_tag;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int set_t_pulses = 0;
  int start_pulses = 0;

  sw_job_controller #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (100),
    .RES_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_job_valid  (i_job_valid),
    .i_job_param  (i_job_param),
    .o_job_ready  (o_job_ready),
    .o_set_t      (o_set_t),
    .o_start_cal  (o_start_cal),
    .o_match      (o_match),
    .o_mismatch   (o_mismatch),
    .o_minusAlpha (o_minusAlpha),
    .o_minusBeta  (o_minusBeta),
    .i_busy       (i_busy),
    .i_valid      (i_valid),
    .i_result     (i_result),
    .o_res_valid  (o_res_valid),
    .o_res_data   (o_res_data),
    .o_res_tag    (o_res_tag),
    .i_res_ready  (i_res_ready),
    .o_error      (o_error),
    .o_best_score (o_best_score),
    .o_best_tag   (o_best_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_set_t)     set_t_pulses++;
    if (o_start_cal) start_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic busy);
    int p0;
    i_job_valid = 1'b0; i_job_param = '0; i_valid = 1'b0;
    i_result = '0; i_res_ready = 1'b0; i_busy = busy;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_job_ready", o_job_ready, 0);
    check("rst_res_valid", o_res_valid, 0);
    check("rst_error", o_error, 0);
    check("rst_set_t", o_set_t, 0);
    p0 = set_t_pulses;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("set_t_high", o_set_t, 1);
    tick();
    check("set_t_low", o_set_t, 0);
    tick();
    check("set_t_once", set_t_pulses - p0, 1);
  endtask

  task automatic push_job(input logic [15:0] p);
    logic ok = 1'b0;
    i_job_valid = 1'b1;
    i_job_param = p;
    for (int k = 0; k < 40; k++) begin
      if (o_job_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("push_ready_seen", ok, 1);
    tick();
    i_job_valid = 1'b0;
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_start_cal) begin
        ok = 1'b1;
        break;
      end
    end
    check("start_seen", ok, 1);
  endtask

  // Engine model: valid is held from START on, so only the WAIT_V value counts.
  task automatic serve_job(input vec_t v);
    int   s0;
    logic ok;
    s0 = start_pulses;
    wait_start(ok);
    if (ok) begin
      check("match", o_match, v.e_match);
      check("mismatch", o_mismatch, v.e_mis);
      check("minus_alpha", o_minusAlpha, v.e_alpha);
      check("minus_beta", o_minusBeta, v.e_beta);
      i_busy = 1'b1; i_valid = 1'b1; i_result = 16'hDEAD;
      tick();
      tick();
      i_result = v.result;
      tick();
      i_valid = 1'b0; i_result = 16'hBEEF; i_busy = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (o_res_valid) begin
          ok = 1'b1;
          break;
        end
      end
      check("res_valid_seen", ok, 1);
      check("res_data", o_res_data, v.e_data);
      check("res_tag", o_res_tag, v.e_tag);
      check("start_once", start_pulses - s0, 1);
      tick();
      check("res_valid_hold", o_res_valid, 1);
      i_res_ready = 1'b1;
      tick();
      i_res_ready = 1'b0;
      check("res_valid_drop", o_res_valid, 0);
    end
  endtask

  vec_t vecs [10];

  initial begin
    vec_t        v;
    logic [15:0] fill [5];
    logic        ok;
    int          s0, p0;

    vecs[0] = '{16'h2131, 16'd12, 4'h2, 4'h1, 4'h3, 4'h1, 16'd12, 3'd0};
    vecs[1] = '{16'hF0A5, 16'd5,  4'hF, 4'h0, 4'hA, 4'h5, 16'd5,  3'd0};
    vecs[2] = '{16'h1234, 16'd9,  4'h1, 4'h2, 4'h3, 4'h4, 16'd9,  3'd1};
    vecs[3] = '{16'h8421, 16'd9,  4'h8, 4'h4, 4'h2, 4'h1, 16'd9,  3'd2};
    vecs[4] = '{16'h0000, 16'd3,  4'h0, 4'h0, 4'h0, 4'h0, 16'd3,  3'd3};
    vecs[5] = '{16'hFFFF, 16'd7,  4'hF, 4'hF, 4'hF, 4'hF, 16'd7,  3'd4};
    vecs[6] = '{16'h5A5A, 16'd1,  4'h5, 4'hA, 4'h5, 4'hA, 16'd1,  3'd5};
    vecs[7] = '{16'hC3E7, 16'd8,  4'hC, 4'h3, 4'hE, 4'h7, 16'd8,  3'd6};
    vecs[8] = '{16'h7001, 16'd2,  4'h7, 4'h0, 4'h0, 4'h1, 16'd2,  3'd7};
    vecs[9] = '{16'h9B6D, 16'd6,  4'h9, 4'hB, 4'h6, 4'hD, 16'd6,  3'd0};

    apply_reset(1'b0);

    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        // Reset while the engine is still busy after a captured result.
        push_job(16'h4321);
        wait_start(ok);
        i_busy = 1'b1;
        tick();
        tick();
        i_valid = 1'b1; i_result = 16'h00AB;
        tick();
        i_valid = 1'b0;
        tick();
        check("wd_res_valid", o_res_valid, 0);
        check("wd_res_data", o_res_data, 16'h00AB);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", o_res_valid, 0);
        check("mid_rst_res_data", o_res_data, 0);
        check("mid_rst_match", o_match, 0);
        check("mid_rst_tag", o_res_tag, 0);
        apply_reset(1'b0);
      end
      push_job(vecs[i].param);
      serve_job(vecs[i]);
    end

`ifdef SW_BEST_SCORE_EN
    check("best_score", o_best_score, 16'd9);
    check("best_tag", o_best_tag, 3'd1);
`else
    check("best_score", o_best_score, 16'd0);
    check("best_tag", o_best_tag, 3'd0);
`endif

    // Fill the FIFO while the engine holds busy in WAIT_T.
    fill = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    apply_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      check("fill_ready", o_job_ready, 1);
      i_job_valid = 1'b1;
      i_job_param = fill[k];
      tick();
    end
    check("full_not_ready", o_job_ready, 0);
    i_job_param = fill[4];
    tick();
    tick();
    check("full_still_blocked", o_job_ready, 0);
    i_busy = 1'b0;
    tick();
    check("pop_frees_ready", o_job_ready, 1);
    tick();
    check("full_after_swap", o_job_ready, 0);
    i_job_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v.param  = fill[k];
      v.result = 16'(20 + k);
      v.e_match = fill[k][15:12];
      v.e_mis   = fill[k][11:8];
      v.e_alpha = fill[k][7:4];
      v.e_beta  = fill[k][3:0];
      v.e_data  = 16'(20 + k);
      v.e_tag   = 3'(k);
      serve_job(v);
    end

    // Engine never reports valid: timeout after 100 cycles of WAIT_V.
    apply_reset(1'b0);
    push_job(16'hABCD);
    wait_start(ok);
    i_busy = 1'b1;
    tick();
    tick();
    repeat (99) tick();
    check("err_before_timeout", o_error, 0);
    tick();
    check("err_at_timeout", o_error, 1);
    check("err_job_ready", o_job_ready, 0);
    s0 = start_pulses;
    p0 = set_t_pulses;
    i_valid = 1'b1; i_job_valid = 1'b1; i_res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_busy = k[0];
      tick();
    end
    check("err_sticky", o_error, 1);
    check("err_ready_low", o_job_ready, 0);
    check("err_no_res_valid", o_res_valid, 0);
    check("err_no_start", start_pulses - s0, 0);
    check("err_no_set_t", set_t_pulses - p0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/sw_job_controller.md
SW_JOB_CONTROLLER -- requirements
Module: sw_job_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning job FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning max cycles waited for any engine handshake.
REQ-003 SHALL have parameter RES_W, default `V_E_F_Bit, meaning result width.
REQ-004 SHALL have ports (one clock; reset is asynchronous and active-low):
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_job_valid  in  1  job offered
i_job_param  in  16  {match[15:12], mismatch[11:8], minusAlpha[7:4], minusBeta[3:0]}
o_job_ready  out  1  job accepted when valid&ready
o_set_t  out  1  engine load-target pulse
o_start_cal  out  1  engine start pulse
o_match, o_mismatch, o_minusAlpha, o_minusBeta  out  4 each  engine scoring parameters
i_busy  in  1  engine busy
i_valid  in  1  engine result valid
i_result  in  RES_W  engine score
o_res_valid  out  1  result available
o_res_data  out  RES_W  captured score
o_res_tag  out  3  job sequence number
i_res_ready  in  1  consumer accepts result
o_error  out  1  sticky timeout flag
o_best_score  out  RES_W  maximum score seen (see Configuration)
o_best_tag  out  3  tag of maximum score

Function
REQ-005 SHALL buffer jobs in a FIFO; o_job_ready = not full and not ERROR; push on i_job_valid&o_job_ready.
REQ-006 SHALL use states INIT, SET_T, WAIT_T, READY, LOAD, START, GUARD, WAIT_V, WAIT_DONE, OUT, ERROR.
REQ-007 INIT -> SET_T one cycle after reset release; SET_T drives o_set_t=1 for exactly one cycle, then WAIT_T.
REQ-008 WAIT_T SHALL ignore i_busy for its first cycle, then go to READY when i_busy=0.
REQ-009 READY SHALL pop the FIFO head when non-empty and go to LOAD; parameter outputs update in LOAD and hold until next pop.
REQ-010 LOAD lasts one cycle (parameter setup); START drives o_start_cal=1 for exactly one cycle; GUARD one cycle; then WAIT_V.
REQ-011 WAIT_V SHALL capture i_result into o_res_data on the first cycle i_valid=1, then WAIT_DONE.
REQ-012 WAIT_DONE -> OUT when i_busy=0; OUT asserts o_res_valid until i_res_ready=1, then READY.
REQ-013 Simultaneous FIFO push and pop in the same cycle SHALL both succeed, including when full.
REQ-014 o_res_tag SHALL be a 3-bit counter incremented per popped job, wrapping 7->0.
REQ-015 A cycle counter SHALL run in WAIT_T, WAIT_V, WAIT_DONE, cleared on entry; reaching TIMEOUT -> ERROR.
REQ-016 ERROR SHALL set o_error=1, deassert o_job_ready, never pulse engine controls; exit only by reset.
REQ-017 i_valid outside WAIT_V SHALL be ignored.

Reset
REQ-018 On rst_n=0 all outputs SHALL go to 0, FIFO empty, tag counter 0, state INIT, immediately.
REQ-019 Reset mid-job SHALL discard the FIFO and any captured result; the set_t sequence reruns after release.

Configuration
REQ-020 With SW_BEST_SCORE_EN defined, o_best_score/o_best_tag SHALL update when a captured score is strictly greater than o_best_score (ties keep earlier tag).
REQ-021 Without SW_BEST_SCORE_EN, o_best_score and o_best_tag SHALL be constant 0 and no comparator is built.

Structure
REQ-022 Shared package sw_pkg SHALL hold the state encoding, parameter-field bit positions, and result width.
REQ-023 FIFO SHALL be a separate sub-module sw_job_fifo (width 16, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-024 Reset release, engine idle -> o_set_t high exactly 1 cycle at 2nd cycle after release; READY reached when i_busy=0.
REQ-025 Push param 16'h2131, engine model returns 12 -> o_match=2, o_mismatch=1, o_minusAlpha=3, o_minusBeta=1; one o_start_cal pulse; o_res_data=12, o_res_tag=0.
REQ-026 Push 5 jobs with FIFO_DEPTH=4 and no pops -> o_job_ready=0 after 4th; 5th accepted on same-cycle pop.
REQ-027 Nine jobs, results 5,9,9,3,... -> tags 0..7,0; with SW_BEST_SCORE_EN o_best_score=9, o_best_tag=1.
REQ-028 i_valid never asserted, TIMEOUT=100 -> o_error=1 at cycle 100 of WAIT_V, o_job_ready=0, no further pulses.
REQ-029 rst_n low during WAIT_DONE with i_res_ready=0 -> o_res_valid=0 immediately; new o_set_t pulse after release.
